// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared state encoding and vector defaults for the interrupt sequencer
package irq_pkg;

    typedef enum logic [2:0] {
        IRQ_IDLE    = 3'd0,
        IRQ_ARM     = 3'd1,
        IRQ_TAKE    = 3'd2,
        IRQ_SERVICE = 3'd3,
        IRQ_RETURN  = 3'd4
    } irq_state_t;

    localparam logic [31:0] IRQ_VEC_BASE_DEF   = 32'h0000_000C;
    localparam int          IRQ_VEC_STRIDE_DEF = 8;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-line synchronizer chain with rising-edge detector
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_line,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // prev resets low, so a line held high through reset still yields one edge
    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - fixed-priority interrupt sequencer issuing flush/redirect to handler vectors
module irq_sequencer
    import irq_pkg::*;
#(
    parameter int          N_IRQ       = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] VEC_BASE    = IRQ_VEC_BASE_DEF,
    parameter int          VEC_STRIDE  = IRQ_VEC_STRIDE_DEF,
    localparam int         ID_W        = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_IRQ-1:0] i_irq_in,
    input  logic             i_en_we,
    input  logic [N_IRQ-1:0] i_en_wdata,
    input  logic             i_gie_we,
    input  logic             i_gie_wdata,
    input  logic             i_pipe_ok,
    input  logic [31:0]      i_resume_pc,
    input  logic             i_eret,
    output logic             o_flush,
    output logic             o_jump_en,
    output logic [31:0]      o_jump_addr,
    output logic [31:0]      o_epc,
    output logic [ID_W-1:0]  o_irq_id,
    output logic [N_IRQ-1:0] o_pending,
    output logic [N_IRQ-1:0] o_enable,
    output logic             o_gie,
    output logic             o_in_service
);

    irq_state_t       r_state;
    irq_state_t       w_next;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_enable;
    logic             r_gie;
    logic [31:0]      r_epc;
    logic [ID_W-1:0]  r_irq_id;

    logic [N_IRQ-1:0] w_edge;
    logic [N_IRQ-1:0] w_req;
    logic [N_IRQ-1:0] w_clr;
    logic [ID_W-1:0]  w_win;
    logic             w_qual;
    logic             w_take_now;
    logic [31:0]      w_vec_addr;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync_edge (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_line (i_irq_in[g]),
            .o_edge (w_edge[g])
        );
    end

    assign w_req  = r_pending & r_enable;
    assign w_qual = r_gie & (|w_req);

    // Scan downward so the lowest requesting index is the last one assigned
    always_comb begin
        w_win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_win = ID_W'(i);
            end
        end
    end

    assign w_take_now = (r_state == IRQ_ARM) && w_qual && i_pipe_ok;
    assign w_clr      = (r_state == IRQ_TAKE) ? (N_IRQ'(1) << r_irq_id) : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IRQ_IDLE:    if (w_qual) w_next = IRQ_ARM;
            IRQ_ARM: begin
                if (!w_qual)        w_next = IRQ_IDLE;
                else if (i_pipe_ok) w_next = IRQ_TAKE;
            end
            IRQ_TAKE:    w_next = IRQ_SERVICE;
            IRQ_SERVICE: if (i_eret) w_next = IRQ_RETURN;
            IRQ_RETURN:  w_next = IRQ_IDLE;
            default:     w_next = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IRQ_IDLE;
            r_pending <= '0;
            r_enable  <= '0;
            r_gie     <= 1'b0;
            r_epc     <= '0;
            r_irq_id  <= '0;
        end else begin
            r_state <= w_next;
            // A fresh edge on the bit being cleared wins over the clear
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (i_en_we)  r_enable <= i_en_wdata;
            if (i_gie_we) r_gie    <= i_gie_wdata;
            if (w_take_now) r_irq_id <= w_win;
            if (r_state == IRQ_TAKE) r_epc <= i_resume_pc;
        end
    end

    assign w_vec_addr = VEC_BASE + (32'(r_irq_id) * 32'(VEC_STRIDE));

    always_comb begin
        o_flush     = 1'b0;
        o_jump_en   = 1'b0;
        o_jump_addr = '0;
        if (r_state == IRQ_TAKE) begin
            o_flush     = 1'b1;
            o_jump_en   = 1'b1;
            o_jump_addr = w_vec_addr;
        end else if (r_state == IRQ_RETURN) begin
            o_flush     = 1'b1;
            o_jump_en   = 1'b1;
            o_jump_addr = r_epc;
        end
    end

    assign o_epc        = r_epc;
    assign o_irq_id     = r_irq_id;
    assign o_pending    = r_pending;
    assign o_enable     = r_enable;
    assign o_gie        = r_gie;
    assign o_in_service = (r_state == IRQ_SERVICE);

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - directed self-checking bench for irq_sequencer
module tb_irq_sequencer;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_in;
    logic        en_we;
    logic [3:0]  en_wdata;
    logic        gie_we;
    logic        gie_wdata;
    logic        pipe_ok;
    logic [31:0] resume_pc;
    logic        eret;
    logic        flush;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic [31:0] epc;
    logic [1:0]  irq_id;
    logic [3:0]  pending;
    logic [3:0]  enable;
    logic        gie;
    logic        in_service;

    int n_cmp = 0;
    int n_err = 0;

    irq_sequencer dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_irq_in    (irq_in),
        .i_en_we     (en_we),
        .i_en_wdata  (en_wdata),
        .i_gie_we    (gie_we),
        .i_gie_wdata (gie_wdata),
        .i_pipe_ok   (pipe_ok),
        .i_resume_pc (resume_pc),
        .i_eret      (eret),
        .o_flush     (flush),
        .o_jump_en   (jump_en),
        .o_jump_addr (jump_addr),
        .o_epc       (epc),
        .o_irq_id    (irq_id),
        .o_pending   (pending),
        .o_enable    (enable),
        .o_gie       (gie),
        .o_in_service(in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_redirect(input string tag, input logic exp_on, input logic [31:0] exp_addr);
        chk({tag, "_flush"}, {31'd0, flush}, {31'd0, exp_on});
        chk({tag, "_jump_en"}, {31'd0, jump_en}, {31'd0, exp_on});
        chk({tag, "_jump_addr"}, jump_addr, exp_addr);
    endtask

    task automatic write_en(input logic [3:0] v);
        en_we = 1'b1; en_wdata = v;
        step();
        en_we = 1'b0;
    endtask

    task automatic write_gie(input logic v);
        gie_we = 1'b1; gie_wdata = v;
        step();
        gie_we = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        step();
        eret = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; en_we = 1'b0; en_wdata = '0;
        gie_we = 1'b0; gie_wdata = 1'b0; pipe_ok = 1'b0;
        resume_pc = '0; eret = 1'b0;

        // reset state
        step(); step();
        chk_redirect("rst", 1'b0, 32'h0);
        chk("rst_pending", {28'd0, pending}, 32'h0);
        chk("rst_enable", {28'd0, enable}, 32'h0);
        chk("rst_gie", {31'd0, gie}, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_irq_id", {30'd0, irq_id}, 32'h0);
        chk("rst_in_service", {31'd0, in_service}, 32'h0);
        reset = 1'b0;

        // single interrupt on line 2
        write_en(4'b0100);
        write_gie(1'b1);
        chk("gie_written", {31'd0, gie}, 32'h1);
        pipe_ok = 1'b1; resume_pc = 32'h40;
        eret = 1'b1; step(); eret = 1'b0;
        chk_redirect("eret_idle", 1'b0, 32'h0);
        irq_in[2] = 1'b1;
        step(); step();
        chk("single_pend_e2", {28'd0, pending}, 32'h0);
        step();
        chk("single_pend_e3", {28'd0, pending}, 32'h4);
        step();
        chk_redirect("single_arm", 1'b0, 32'h0);
        step();
        chk_redirect("single_take", 1'b1, 32'h1C);
        chk("single_irq_id", {30'd0, irq_id}, 32'h2);
        step();
        chk_redirect("single_svc", 1'b0, 32'h0);
        chk("single_in_service", {31'd0, in_service}, 32'h1);
        chk("single_epc", epc, 32'h40);
        chk("single_pend_clr", {28'd0, pending}, 32'h0);
        irq_in[2] = 1'b0;
        step();
        chk("single_svc_hold", {31'd0, in_service}, 32'h1);
        pulse_eret();
        chk_redirect("single_ret", 1'b1, 32'h40);
        step();
        chk_redirect("single_idle", 1'b0, 32'h0);
        chk("single_out_svc", {31'd0, in_service}, 32'h0);

        // priority and masking: lines 1 and 3 together
        write_en(4'b1010);
        resume_pc = 32'h80;
        irq_in[1] = 1'b1; irq_in[3] = 1'b1;
        step(); step(); step();
        chk("prio_pend", {28'd0, pending}, 32'hA);
        step();
        step();
        chk_redirect("prio_take1", 1'b1, 32'h14);
        chk("prio_id1", {30'd0, irq_id}, 32'h1);
        step();
        chk("prio_pend_svc", {28'd0, pending}, 32'h8);
        step(); step();
        chk("prio_still_svc", {31'd0, in_service}, 32'h1);
        chk("prio_pend_hold", {28'd0, pending}, 32'h8);
        pulse_eret();
        chk_redirect("prio_ret1", 1'b1, 32'h80);
        step();
        chk_redirect("prio_idle_gap", 1'b0, 32'h0);
        step();
        chk_redirect("prio_arm2", 1'b0, 32'h0);
        step();
        chk_redirect("prio_take3", 1'b1, 32'h24);
        chk("prio_id3", {30'd0, irq_id}, 32'h3);
        step();
        chk("prio_pend_empty", {28'd0, pending}, 32'h0);
        pulse_eret();
        chk_redirect("prio_ret3", 1'b1, 32'h80);
        irq_in = '0;
        step();
        step(); step(); step();

        // stall in ARM: line 3 pending, line 0 arrives during the stall
        write_en(4'b1001);
        pipe_ok = 1'b0; resume_pc = 32'hC0;
        irq_in[3] = 1'b1;
        step(); step(); step(); step();
        chk("stall_pend3", {28'd0, pending}, 32'h8);
        irq_in[0] = 1'b1;
        step(); step();
        chk_redirect("stall_hold", 1'b0, 32'h0);
        step();
        chk("stall_pend_both", {28'd0, pending}, 32'h9);
        step(); step(); step();
        chk_redirect("stall_hold_end", 1'b0, 32'h0);
        pipe_ok = 1'b1;
        step();
        chk_redirect("stall_take0", 1'b1, 32'h0C);
        chk("stall_id0", {30'd0, irq_id}, 32'h0);
        step();
        chk("stall_pend_left", {28'd0, pending}, 32'h8);
        chk("stall_epc", epc, 32'hC0);
        pulse_eret();
        chk_redirect("stall_ret", 1'b1, 32'hC0);
        pipe_ok = 1'b0;
        step();
        step();

        // disable in ARM: gie dropped while line 3 waits for pipe_ok
        write_gie(1'b0);
        step();
        pipe_ok = 1'b1;
        step(); step();
        chk_redirect("gie_off_noflush", 1'b0, 32'h0);
        chk("gie_off_pend", {28'd0, pending}, 32'h8);
        chk("gie_off_svc", {31'd0, in_service}, 32'h0);
        irq_in = '0;
        write_gie(1'b1);
        step();
        step();
        chk_redirect("gie_on_take3", 1'b1, 32'h24);
        step();
        pulse_eret();
        chk_redirect("gie_on_ret", 1'b1, 32'hC0);
        step();

        // edge race: new edge on line 2 during its own TAKE cycle
        write_en(4'b0100);
        resume_pc = 32'h100;
        irq_in[2] = 1'b1;
        step();
        irq_in[2] = 1'b0;
        step(); step();
        irq_in[2] = 1'b1;
        step();
        step();
        chk_redirect("race_take", 1'b1, 32'h1C);
        step();
        chk("race_pend_kept", {28'd0, pending}, 32'h4);
        chk("race_svc", {31'd0, in_service}, 32'h1);

        // reset during SERVICE, line 2 held high through reset
        reset = 1'b1;
        #1;
        chk_redirect("svc_rst", 1'b0, 32'h0);
        chk("svc_rst_in_service", {31'd0, in_service}, 32'h0);
        chk("svc_rst_pending", {28'd0, pending}, 32'h0);
        chk("svc_rst_epc", epc, 32'h0);
        chk("svc_rst_enable", {28'd0, enable}, 32'h0);
        step();
        reset = 1'b0;
        pulse_eret();
        chk_redirect("post_rst_eret", 1'b0, 32'h0);
        chk("post_rst_svc", {31'd0, in_service}, 32'h0);
        step();
        step();
        chk("post_rst_edge", {28'd0, pending}, 32'h4);
        step(); step();
        chk_redirect("post_rst_masked", 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
